// File: rtl/psram_cr_sequencer.sv
// rtl/psram_cr_sequencer.sv - PSRAM configuration-register access sequencer (optional CR_READBACK_EN)
module psram_cr_sequencer #(
    parameter int ADDR_W = 23,
    parameter int T_ACC  = 6,
    parameter int T_REC  = 2
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              dt_req,
    output logic              dt_ack,
    input  logic              dt_rw,
    input  logic [15:0]       data_to_cr,
    output logic [15:0]       data_from_cr,
    input  logic [31:0]       max_addr,
    input  logic [31:0]       reg_addr,
    output logic              cr_bus_req,
    input  logic              cr_bus_gnt,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_dq_o,
    input  logic [15:0]       mem_dq_i,
    output logic              mem_dq_oe,
    output logic              mem_ce_n,
    output logic              mem_oe_n,
    output logic              mem_we_n,
    output logic              mem_ub_n,
    output logic              mem_lb_n
);

    typedef enum logic [2:0] {
        S_IDLE, S_GNT_WAIT, S_SETUP, S_ACTIVE, S_RECOVER, S_ACK
    } state_t;

    localparam logic [7:0] ACC_LAST = 8'(T_ACC - 1);
    localparam logic [7:0] REC_LAST = 8'(T_REC - 1);

    state_t            state, state_nx;
    logic [7:0]        cnt, cnt_nx;
    logic [1:0]        idx, idx_nx;
    logic              pass, pass_nx;
    logic [ADDR_W-1:0] addr_l;
    logic [1:0]        sel_l;
    logic              rw_l;
    logic [15:0]       data_l;
    logic              rb_pending;
    logic              wr_cur, wr_nx;
    logic [15:0]       wdata_nx;

    logic              ack_d, req_d, ce_d, oe_d, we_d, bs_d, dq_oe_d;
    logic [ADDR_W-1:0] addr_d;
    logic [15:0]       dq_o_d, from_d;

    // Address bits above the PSRAM width and the register-select upper bits have no function
    logic unused_bits;
    assign unused_bits = ^{max_addr[31:ADDR_W], reg_addr[31:2]};

`ifdef CR_READBACK_EN
    assign rb_pending = rw_l & ~pass;
`else
    assign rb_pending = 1'b0;
`endif

    // Access idx 2 always writes the register select; idx 3 writes only on the first pass of a write op
    assign wr_cur   = (idx == 2'd2) || (idx == 2'd3 && rw_l && !pass);
    assign wr_nx    = (idx_nx == 2'd2) || (idx_nx == 2'd3 && rw_l && !pass_nx);
    assign wdata_nx = (idx_nx == 2'd2) ? {14'b0, sel_l} : data_l;

    // State register, request latches and registered outputs
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state        <= S_IDLE;
            cnt          <= '0;
            idx          <= '0;
            pass         <= 1'b0;
            addr_l       <= '0;
            sel_l        <= '0;
            rw_l         <= 1'b0;
            data_l       <= '0;
            dt_ack       <= 1'b0;
            cr_bus_req   <= 1'b0;
            data_from_cr <= '0;
            mem_addr     <= '0;
            mem_dq_o     <= '0;
            mem_dq_oe    <= 1'b0;
            mem_ce_n     <= 1'b1;
            mem_oe_n     <= 1'b1;
            mem_we_n     <= 1'b1;
            mem_ub_n     <= 1'b1;
            mem_lb_n     <= 1'b1;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            idx   <= idx_nx;
            pass  <= pass_nx;
            if (state == S_IDLE && state_nx == S_GNT_WAIT) begin
                addr_l <= max_addr[ADDR_W-1:0];
                sel_l  <= reg_addr[1:0];
                rw_l   <= dt_rw;
                data_l <= data_to_cr;
            end
            dt_ack       <= ack_d;
            cr_bus_req   <= req_d;
            data_from_cr <= from_d;
            mem_addr     <= addr_d;
            mem_dq_o     <= dq_o_d;
            mem_dq_oe    <= dq_oe_d;
            mem_ce_n     <= ce_d;
            mem_oe_n     <= oe_d;
            mem_we_n     <= we_d;
            mem_ub_n     <= bs_d;
            mem_lb_n     <= bs_d;
        end
    end

    // Next state plus access index, pass and phase counter
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        idx_nx   = idx;
        pass_nx  = pass;
        case (state)
            S_IDLE: begin
                if (dt_req && !dt_ack) begin
                    state_nx = S_GNT_WAIT;
                    idx_nx   = 2'd0;
                    pass_nx  = 1'b0;
                end
            end
            S_GNT_WAIT: if (cr_bus_gnt) state_nx = S_SETUP;
            S_SETUP: begin
                state_nx = S_ACTIVE;
                cnt_nx   = '0;
            end
            S_ACTIVE: begin
                if (cnt == ACC_LAST) begin
                    state_nx = S_RECOVER;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 8'd1;
                end
            end
            S_RECOVER: begin
                if (cnt == REC_LAST) begin
                    if (idx != 2'd3) begin
                        state_nx = S_SETUP;
                        idx_nx   = idx + 2'd1;
                    end else if (rb_pending) begin
                        state_nx = S_SETUP;
                        idx_nx   = 2'd0;
                        pass_nx  = 1'b1;
                    end else begin
                        state_nx = S_ACK;
                    end
                end else begin
                    cnt_nx = cnt + 8'd1;
                end
            end
            S_ACK:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Output values for the coming cycle, derived from the next state
    always_comb begin
        ack_d   = 1'b0;
        req_d   = 1'b0;
        ce_d    = 1'b1;
        oe_d    = 1'b1;
        we_d    = 1'b1;
        bs_d    = 1'b1;
        dq_oe_d = 1'b0;
        addr_d  = mem_addr;
        dq_o_d  = mem_dq_o;
        from_d  = data_from_cr;
        case (state_nx)
            S_GNT_WAIT, S_RECOVER: req_d = 1'b1;
            S_SETUP: begin
                req_d   = 1'b1;
                ce_d    = 1'b0;
                bs_d    = 1'b0;
                addr_d  = addr_l;
                dq_oe_d = wr_nx;
                if (wr_nx) dq_o_d = wdata_nx;
            end
            S_ACTIVE: begin
                req_d   = 1'b1;
                ce_d    = 1'b0;
                bs_d    = 1'b0;
                oe_d    = wr_nx;
                we_d    = ~wr_nx;
                dq_oe_d = wr_nx;
            end
            S_ACK:   ack_d = 1'b1;
            default: ack_d = 1'b0;
        endcase
        if (state == S_ACTIVE && cnt == ACC_LAST && idx == 2'd3 && !wr_cur)
            from_d = mem_dq_i;
`ifndef CR_READBACK_EN
        if (state_nx == S_ACK && rw_l)
            from_d = data_l;
`endif
    end

endmodule
